sdram_bridge: RTL and testbench
===============================

// Module: sdram_bridge
// PURPOSE
//  CPU-side front end for the SDRAM controller: turns CPU word/byte accesses (req/ack, pause) into
//  one-cycle controller command pulses (read/write/refresh). Performs read-modify-write for partial
//  byte writes (controller always writes full words). Owns the periodic auto-refresh timer.
// PARAMETERS
//  FREQ        60_000_000  I_clk frequency in Hz
//  REFRESH_US  15          refresh interval in us; REF_CYC = FREQ/1_000_000*REFRESH_US (900 default)
// PORTS
//  I_clk             in   1   system clock (same clock as controller I_clk)
//  I_rst_n           in   1   reset: one clock; reset is synchronous and active-low
//  I_cpu_req         in   1   access request; held, with addr/we/data stable, until O_cpu_ack
//  I_cpu_address     in   23  byte address; bits[1:0] ignored, passed through unchanged
//  I_cpu_byte_we     in   4   byte enables; bit i = data[8i+7:8i]; 0 = read
//  I_cpu_data_w      in   32  write data
//  O_cpu_data_r      out  32  read data; valid in ack cycle, held until next read completes
//  O_cpu_ack         out  1   one-cycle completion pulse
//  O_cpu_pause       out  1   I_cpu_req & ~O_cpu_ack (combinational CPU stall)
//  O_sd_cmd_read     out  1   controller read pulse
//  O_sd_cmd_write    out  1   controller write pulse
//  O_sd_cmd_refresh  out  1   controller auto-refresh pulse
//  O_sd_address      out  23  address to controller
//  O_sd_data_in      out  32  write data to controller
//  I_sd_data_out     in   32  read data from controller
//  I_sd_data_ready   in   1   read data valid strobe
//  I_sd_busy         in   1   controller busy (1 during init and every op)
//  O_refresh_miss    out  1   sticky: refresh interval expired while previous refresh still pending
// BEHAVIOUR
//  Reset: all O_ outputs 0 (pause follows I_cpu_req), FSM=IDLE, ref counter=REF_CYC-1, pending=0.
//  Commands: at most one pulse per issue, exactly one cycle wide, only in a cycle with I_sd_busy=0.
//   Controller registers busy on the issue edge; busy=1 from the next cycle, so WAIT states simply
//   wait for I_sd_busy=0. Address/data outputs registered with the pulse and held until next issue.
//  FSM states: IDLE, RD_WAIT, RMW_WAIT, WR_WAIT, REF_WAIT, ACK.
//   IDLE & busy=0: pending -> refresh pulse, clear pending, REF_WAIT (refresh wins over req);
//    else req & we=0 -> read, RD_WAIT; req & we=4'hF -> write(data_w), WR_WAIT;
//    else req -> read, RMW_WAIT. IDLE & busy=1 (incl. controller init): issue nothing.
//   RD_WAIT: on data_ready capture I_sd_data_out to O_cpu_data_r; busy=0 -> ACK.
//   RMW_WAIT: on data_ready merge lane i = we[i] ? data_w : read data into write buffer;
//    busy=0 -> write pulse with merged word, WR_WAIT (refresh never splits an RMW).
//   WR_WAIT: busy=0 -> ACK.  REF_WAIT: busy=0 -> IDLE.  ACK: O_cpu_ack=1 one cycle -> IDLE.
//  Handshake: requester changes/drops req on the edge ending the ack cycle; req seen in IDLE after
//   ACK is a new access. Back-to-back accesses: ack cycle + >=1 IDLE cycle between ops.
//  Latency (ack after issue): controller op time + 1 (ACK); RMW = read op + write op + 1.
//  Refresh timer: free-running down-counter, independent of FSM; at 0 reloads REF_CYC-1 and sets
//   pending; if pending already 1 -> O_refresh_miss=1 (sticky until reset), pending stays 1.
//   Set and clear in same cycle: set wins.
//  Reset mid-operation: FSM -> IDLE, no ack for the aborted access, no command pulse.
// STRUCTURE
//  Shared include sdram_defs.vh: FSM state encodings, byte-lane merge width constants, REF_CYC calc.
//  Sub-module sdram_refresh_timer (counter, pending, miss flag; input clear_pending).
//  Merge mux and FSM stay in sdram_bridge.
// TESTING (bench: behavioural controller model, busy/data_ready timing as real controller)
//  Init: busy=1 for 50 cycles after reset, req read -> no command until busy=0, then one read pulse.
//  Write 0x000104 we=F data 0xDEADBEEF -> one write pulse, sd addr 0x000104, data 0xDEADBEEF, no read, ack.
//  Read 0x000104, model returns 0xDEADBEEF -> O_cpu_data_r=0xDEADBEEF in ack cycle, pause low then.
//  RMW we=4'b0010 data 0x00005500 on word 0x11223344 -> read then write 0x11225544, single ack.
//  Idle after reset -> refresh pulse at cycle 900 and every 900; req coincident with pending -> refresh first.
//  Hold busy=1 for 2000 cycles -> O_refresh_miss=1, exactly one refresh issued after busy falls.

Source files
------------

// File: rtl/sdram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bridge_pkg
// Purpose  : Shared definitions for the SDRAM CPU bridge: FSM state
//            encodings, byte-lane geometry, refresh interval calculation and
//            the read-modify-write byte-lane merge helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package sdram_bridge_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_WAIT  = 3'd1;
    localparam logic [2:0] ST_RMW_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_WAIT  = 3'd3;
    localparam logic [2:0] ST_REF_WAIT = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;

    // Clock cycles between refresh requests. Divide first so the
    // intermediate product cannot overflow 32 bits.
    function automatic int unsigned ref_cycles(input int unsigned freq,
                                               input int unsigned us);
        return (freq / 1_000_000) * us;
    endfunction

    // Enabled lanes come from the CPU write data, the rest from memory.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [LANES-1:0]  we,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] rdata
    );
        logic [DATA_W-1:0] m;
        m = rdata;
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                m[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_bridge_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bridge_refresh_timer
// Purpose  : Free-running auto-refresh interval timer. Raises a pending
//            request every REF_CYC clocks and flags a sticky miss when an
//            interval expires before the previous request was served.
// Ports    : I_clk            clock
//            I_rst_n          synchronous active-low reset
//            I_clear_pending  refresh issued this cycle
//            O_pending        refresh request outstanding
//            O_refresh_miss   sticky overrun flag
// Revision : 1.0  initial release
// ============================================================================
module sdram_bridge_refresh_timer #(
    parameter int unsigned REF_CYC = 900
) (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_clear_pending,
    output logic O_pending,
    output logic O_refresh_miss
);

    localparam int CNT_W = (REF_CYC > 1) ? $clog2(REF_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             miss_q, miss_d;

    always_comb begin
        cnt_d     = cnt_q - CNT_W'(1);
        pending_d = pending_q & ~I_clear_pending;
        miss_d    = miss_q;
        if (cnt_q == '0) begin
            cnt_d     = RELOAD;
            // A new expiry outranks a clear in the same cycle.
            pending_d = 1'b1;
            if (pending_q) begin
                miss_d = 1'b1;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
        end
    end

    assign O_pending      = pending_q;
    assign O_refresh_miss = miss_q;

endmodule
`default_nettype wire

// File: rtl/sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bridge
// Purpose  : CPU front end for the SDRAM controller. Converts held CPU
//            requests into one-cycle read/write/refresh command pulses,
//            performs read-modify-write for partial byte writes and owns
//            the auto-refresh timer.
// Ports    : I_clk, I_rst_n                  clock, sync active-low reset
//            I_cpu_*, O_cpu_*                CPU request/ack/pause interface
//            O_sd_cmd_*, O_sd_address,
//            O_sd_data_in                    command pulses + operands
//            I_sd_data_out, I_sd_data_ready,
//            I_sd_busy                       controller status/read data
//            O_refresh_miss                  sticky refresh overrun flag
// Revision : 1.0  initial release
// ============================================================================
module sdram_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned FREQ       = 60_000_000,
    parameter int unsigned REFRESH_US = 15
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_cpu_req,
    input  logic [ADDR_W-1:0] I_cpu_address,
    input  logic [LANES-1:0]  I_cpu_byte_we,
    input  logic [DATA_W-1:0] I_cpu_data_w,
    output logic [DATA_W-1:0] O_cpu_data_r,
    output logic              O_cpu_ack,
    output logic              O_cpu_pause,
    output logic              O_sd_cmd_read,
    output logic              O_sd_cmd_write,
    output logic              O_sd_cmd_refresh,
    output logic [ADDR_W-1:0] O_sd_address,
    output logic [DATA_W-1:0] O_sd_data_in,
    input  logic [DATA_W-1:0] I_sd_data_out,
    input  logic              I_sd_data_ready,
    input  logic              I_sd_busy,
    output logic              O_refresh_miss
);

    localparam int unsigned REF_CYC = ref_cycles(FREQ, REFRESH_US);

    logic [2:0]        state_q, state_d;
    logic              rd_q, rd_d, wr_q, wr_d, ref_q, ref_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic              clear_pending;
    logic              pending;
    logic              issued;
    logic              done;
    logic [DATA_W-1:0] merged;

    sdram_bridge_refresh_timer #(
        .REF_CYC (REF_CYC)
    ) u_refresh_timer (
        .I_clk           (I_clk),
        .I_rst_n         (I_rst_n),
        .I_clear_pending (clear_pending),
        .O_pending       (pending),
        .O_refresh_miss  (O_refresh_miss)
    );

    // While a command pulse is on the bus the controller has not yet
    // registered busy, so busy=0 in that cycle does not mean "finished".
    assign issued = rd_q | wr_q | ref_q;
    assign done   = ~issued & ~I_sd_busy;
    assign merged = merge_lanes(I_cpu_byte_we, I_cpu_data_w, I_sd_data_out);

    always_comb begin
        state_d       = state_q;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        ref_d         = 1'b0;
        addr_d        = addr_q;
        sdata_d       = sdata_q;
        rdata_d       = rdata_q;
        wbuf_d        = wbuf_q;
        clear_pending = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!I_sd_busy) begin
                    if (pending) begin
                        ref_d         = 1'b1;
                        clear_pending = 1'b1;
                        state_d       = ST_REF_WAIT;
                    end else if (I_cpu_req) begin
                        addr_d = I_cpu_address;
                        if (I_cpu_byte_we == '0) begin
                            rd_d    = 1'b1;
                            state_d = ST_RD_WAIT;
                        end else if (I_cpu_byte_we == '1) begin
                            wr_d    = 1'b1;
                            sdata_d = I_cpu_data_w;
                            state_d = ST_WR_WAIT;
                        end else begin
                            rd_d    = 1'b1;
                            state_d = ST_RMW_WAIT;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                if (I_sd_data_ready) begin
                    rdata_d = I_sd_data_out;
                end
                if (done) begin
                    state_d = ST_ACK;
                end
            end
            ST_RMW_WAIT: begin
                if (I_sd_data_ready) begin
                    wbuf_d = merged;
                end
                // Read data may arrive in the same cycle busy drops, so the
                // write takes the live merge rather than the stale buffer.
                if (done) begin
                    wr_d    = 1'b1;
                    sdata_d = I_sd_data_ready ? merged : wbuf_q;
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (done) begin
                    state_d = ST_ACK;
                end
            end
            ST_REF_WAIT: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ref_q   <= 1'b0;
            addr_q  <= '0;
            sdata_q <= '0;
            rdata_q <= '0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ref_q   <= ref_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            rdata_q <= rdata_d;
            wbuf_q  <= wbuf_d;
        end
    end

    assign O_cpu_ack        = (state_q == ST_ACK);
    assign O_cpu_pause      = I_cpu_req & ~O_cpu_ack;
    assign O_cpu_data_r     = rdata_q;
    assign O_sd_cmd_read    = rd_q;
    assign O_sd_cmd_write   = wr_q;
    assign O_sd_cmd_refresh = ref_q;
    assign O_sd_address     = addr_q;
    assign O_sd_data_in     = sdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_bridge
// Purpose  : Directed self-checking bench for sdram_bridge with a
//            behavioural SDRAM controller (50-cycle init busy, 4-cycle ops,
//            data_ready coincident with busy falling).
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [22:0] addr = '0;
    logic [3:0]  bwe = '0;
    logic [31:0] wdat = '0;
    logic [31:0] data_r;
    logic        ack, pause;
    logic        cmd_rd, cmd_wr, cmd_ref;
    logic [22:0] sd_addr;
    logic [31:0] sd_din;
    logic [31:0] sd_dout = '0;
    logic        sd_ready = 1'b0;
    logic        mbusy = 1'b1;
    logic        hold = 1'b0;
    logic        busy_bus;
    logic        miss;

    assign busy_bus = mbusy | hold;

    always #5 clk = ~clk;

    sdram_bridge #(.FREQ(60_000_000), .REFRESH_US(15)) dut (
        .I_clk            (clk),
        .I_rst_n          (rst_n),
        .I_cpu_req        (req),
        .I_cpu_address    (addr),
        .I_cpu_byte_we    (bwe),
        .I_cpu_data_w     (wdat),
        .O_cpu_data_r     (data_r),
        .O_cpu_ack        (ack),
        .O_cpu_pause      (pause),
        .O_sd_cmd_read    (cmd_rd),
        .O_sd_cmd_write   (cmd_wr),
        .O_sd_cmd_refresh (cmd_ref),
        .O_sd_address     (sd_addr),
        .O_sd_data_in     (sd_din),
        .I_sd_data_out    (sd_dout),
        .I_sd_data_ready  (sd_ready),
        .I_sd_busy        (busy_bus),
        .O_refresh_miss   (miss)
    );

    // ---------------- behavioural controller model ----------------
    int          cyc = 0;
    int          init_cnt = 0;
    int          op_cnt = 0;
    logic        op_rd = 1'b0, op_wr = 1'b0;
    logic [22:0] op_a = '0;
    logic [31:0] op_d = '0;
    logic [31:0] mem [0:255];
    int          rd_cnt = 0, wr_cnt = 0, ref_cnt = 0, illegal = 0, ack_cnt = 0;
    int          rd_cyc = 0, ref_cyc = 0;
    logic [22:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    always @(posedge clk) begin
        cyc <= rst_n ? cyc + 1 : 0;
        if (rst_n && ack) ack_cnt <= ack_cnt + 1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            init_cnt <= 50;
            mbusy    <= 1'b1;
            op_cnt   <= 0;
            sd_ready <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 + i;
        end else begin
            sd_ready <= 1'b0;
            if (init_cnt != 0) begin
                init_cnt <= init_cnt - 1;
                if (init_cnt == 1) mbusy <= 1'b0;
            end
            if (op_cnt != 0) begin
                op_cnt <= op_cnt - 1;
                if (op_cnt == 1) begin
                    mbusy <= 1'b0;
                    if (op_rd) begin
                        sd_ready <= 1'b1;
                        sd_dout  <= mem[op_a[9:2]];
                    end
                    if (op_wr) mem[op_a[9:2]] <= op_d;
                end
            end
            if (cmd_rd || cmd_wr || cmd_ref) begin
                if ((int'(cmd_rd) + int'(cmd_wr) + int'(cmd_ref)) > 1 || busy_bus)
                    illegal <= illegal + 1;
                mbusy  <= 1'b1;
                op_cnt <= 4;
                op_rd  <= cmd_rd;
                op_wr  <= cmd_wr;
                op_a   <= sd_addr;
                op_d   <= sd_din;
                if (cmd_rd)  begin rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; end
                if (cmd_ref) begin ref_cnt <= ref_cnt + 1; ref_cyc <= cyc; end
                if (cmd_wr)  begin wr_cnt <= wr_cnt + 1; last_wa <= sd_addr; last_wd <= sd_din; end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output logic [31:0] rdat, output logic p_at_ack, output logic got);
        got = 1'b0; rdat = '0; p_at_ack = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1'b1; rdat = data_r; p_at_ack = pause; end
        end
        req = 1'b0; bwe = '0;
        @(posedge clk); #1;
    endtask

    task automatic access(input logic [22:0] a, input logic [3:0] we, input logic [31:0] d,
                          output logic [31:0] rdat, output logic p_at_ack, output logic got);
        addr = a; bwe = we; wdat = d; req = 1'b1;
        wait_ack(rdat, p_at_ack, got);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 100000 && cyc != target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rd;
    logic        pa, got;
    int          r0, w0, a0, f0;

    initial begin
        // ---- reset state ----
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_cmds", {29'd0, cmd_rd, cmd_wr, cmd_ref}, 32'd0);
        check("rst_data_r", data_r, 32'h0);
        check("rst_sd_addr", {9'd0, sd_addr}, 32'h0);
        check("rst_miss", {31'd0, miss}, 32'd0);
        check("rst_pause_lo", {31'd0, pause}, 32'd0);
        req = 1'b1; #1;
        check("rst_pause_req", {31'd0, pause}, 32'd1);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- read during controller init: issued only once busy falls ----
        r0 = rd_cnt; w0 = wr_cnt;
        access(23'h000200, 4'h0, 32'h0, rd, pa, got);
        check("init_ack", {31'd0, got}, 32'd1);
        check("init_rd_cyc", rd_cyc, 32'd51);
        check("init_rd_cnt", rd_cnt - r0, 32'd1);
        check("init_data", rd, 32'hA5A5_0080);

        // ---- full word write ----
        r0 = rd_cnt; w0 = wr_cnt; a0 = ack_cnt;
        access(23'h000104, 4'hF, 32'hDEADBEEF, rd, pa, got);
        check("wr_ack", {31'd0, got}, 32'd1);
        check("wr_count", wr_cnt - w0, 32'd1);
        check("wr_no_read", rd_cnt - r0, 32'd0);
        check("wr_addr", {9'd0, last_wa}, 32'h000104);
        check("wr_data", last_wd, 32'hDEADBEEF);

        // ---- read back ----
        access(23'h000104, 4'h0, 32'h0, rd, pa, got);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_pause_at_ack", {31'd0, pa}, 32'd0);

        // ---- read-modify-write, byte address passed through ----
        access(23'h000108, 4'hF, 32'h11223344, rd, pa, got);
        r0 = rd_cnt; w0 = wr_cnt; a0 = ack_cnt;
        access(23'h00010A, 4'b0010, 32'h00005500, rd, pa, got);
        repeat (5) @(posedge clk);
        #1;
        check("rmw_reads", rd_cnt - r0, 32'd1);
        check("rmw_writes", wr_cnt - w0, 32'd1);
        check("rmw_data", last_wd, 32'h11225544);
        check("rmw_addr", {9'd0, last_wa}, 32'h00010A);
        check("rmw_single_ack", ack_cnt - a0, 32'd1);
        access(23'h000108, 4'h0, 32'h0, rd, pa, got);
        check("rmw_readback", rd, 32'h11225544);

        // ---- refresh timing from a fresh reset ----
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        f0 = ref_cnt;
        for (int i = 0; i < 1000 && ref_cnt == f0; i++) begin @(posedge clk); #1; end
        check("ref_first_cyc", ref_cyc, 32'd901);
        for (int i = 0; i < 1000 && ref_cnt == f0 + 1; i++) begin @(posedge clk); #1; end
        check("ref_second_cyc", ref_cyc, 32'd1801);

        // ---- request coincident with pending refresh ----
        wait_cyc(2600);
        hold = 1'b1;
        addr = 23'h000040; bwe = 4'h0; req = 1'b1;
        wait_cyc(2750);
        hold = 1'b0;
        wait_ack(rd, pa, got);
        check("coinc_ref_cyc", ref_cyc, 32'd2751);
        check("coinc_rd_cyc", rd_cyc, 32'd2758);
        check("coinc_data", rd, 32'hA5A5_0010);

        // ---- refresh overrun ----
        wait_cyc(2800);
        check("miss_before", {31'd0, miss}, 32'd0);
        hold = 1'b1;
        f0 = ref_cnt;
        wait_cyc(4800);
        check("miss_set", {31'd0, miss}, 32'd1);
        check("ref_none_while_busy", ref_cnt - f0, 32'd0);
        hold = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("ref_one_after_busy", ref_cnt - f0, 32'd1);

        // ---- reset mid operation ----
        addr = 23'h000010; bwe = 4'hF; wdat = 32'h0BADF00D; req = 1'b1;
        w0 = wr_cnt;
        for (int i = 0; i < 300 && wr_cnt == w0; i++) begin @(posedge clk); #1; end
        check("mid_wr_issued", wr_cnt - w0, 32'd1);
        rst_n = 1'b0; req = 1'b0; bwe = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a0 = ack_cnt; r0 = rd_cnt + wr_cnt + ref_cnt;
        repeat (60) @(posedge clk);
        #1;
        check("mid_no_ack", ack_cnt - a0, 32'd0);
        check("mid_no_cmd", rd_cnt + wr_cnt + ref_cnt - r0, 32'd0);
        check("mid_miss_clr", {31'd0, miss}, 32'd0);

        check("illegal_cmds", illegal, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
